// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 @ 60 Hz VGA pixel-timing generator (25 MHz pixel clock).
// Produces sync_h/sync_v (active low), video_on, raw x/y counters and a frame_start pulse.
// Optional macro VGA_SYNC_OUTREG_EN registers every output (one-clock lag, mutually aligned);
// without it the outputs are zero-latency combinational decodes of the counters.
module vga_sync_gen #(
    parameter int unsigned H_DISP = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_DISP = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       sync_h,
    output logic       sync_v,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    localparam int unsigned CNT_W = 10;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;

    logic sync_h_c;
    logic sync_v_c;
    logic video_on_c;
    logic frame_start_c;

    // Pixel and line counters; the line counter advances only when the pixel counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (vcnt == V_LAST) begin
                vcnt <= '0;
            end else begin
                vcnt <= vcnt + CNT_W'(1);
            end
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    // Timing decodes of the current counter values.
    always_comb begin
        sync_h_c      = 1'b1;
        sync_v_c      = 1'b1;
        video_on_c    = 1'b0;
        frame_start_c = 1'b0;
        if ((hcnt >= HS_FIRST) && (hcnt <= HS_LAST)) begin
            sync_h_c = 1'b0;
        end
        if ((vcnt >= VS_FIRST) && (vcnt <= VS_LAST)) begin
            sync_v_c = 1'b0;
        end
        if ((hcnt < H_VIS) && (vcnt < V_VIS)) begin
            video_on_c = 1'b1;
        end
        if ((hcnt == '0) && (vcnt == '0)) begin
            frame_start_c = 1'b1;
        end
    end

`ifdef VGA_SYNC_OUTREG_EN
    // Output stage: all outputs sampled together so they stay aligned one clock behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_h      <= 1'b1;
            sync_v      <= 1'b1;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            sync_h      <= sync_h_c;
            sync_v      <= sync_v_c;
            video_on    <= video_on_c;
            x           <= hcnt;
            y           <= vcnt;
            frame_start <= frame_start_c;
        end
    end
`else
    // Zero-latency outputs straight from the counter decodes.
    always_comb begin
        sync_h      = sync_h_c;
        sync_v      = sync_v_c;
        video_on    = video_on_c;
        x           = hcnt;
        y           = vcnt;
        frame_start = frame_start_c;
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a full-size instance covers reset, horizontal timing,
// line wrap and mid-frame reset; a shrunken-timing instance (16x13) covers vertical sync,
// frame wrap and frame period within a short run. Works with or without VGA_SYNC_OUTREG_EN.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_OUTREG_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic       clk;
    logic       rst;
    logic       rst_s;

    logic       sync_h, sync_v, video_on, frame_start;
    logic [9:0] x, y;
    logic       sync_h_s, sync_v_s, video_on_s, frame_start_s;
    logic [9:0] x_s, y_s;

    int tests;
    int fails;
    int cyc;

    vga_sync_gen dut (
        .clk         (clk),
        .rst         (rst),
        .sync_h      (sync_h),
        .sync_v      (sync_v),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .frame_start (frame_start)
    );

    // Small timing: line = 8+2+3+3 = 16 clocks, frame = 6+2+2+3 = 13 lines = 208 clocks.
    vga_sync_gen #(
        .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk         (clk),
        .rst         (rst_s),
        .sync_h      (sync_h_s),
        .sync_v      (sync_v_s),
        .video_on    (video_on_s),
        .x           (x_s),
        .y           (y_s),
        .frame_start (frame_start_s)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance until outputs reflect the counter value reached after t edges since release.
    task automatic goto(input int t);
        while (cyc < t + LAG) step();
    endtask

    initial begin
        int lows;
        int highs;
        int first_low;
        int von_bad;
        int von_on;
        int n;

        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        rst_s = 1'b0;
        cyc   = 0;

        // Reset values
`ifdef VGA_SYNC_OUTREG_EN
        check("rst_x",  int'(x), 0);
        check("rst_y",  int'(y), 0);
        check("rst_von", int'(video_on), 0);
        check("rst_hs", int'(sync_h), 1);
        check("rst_vs", int'(sync_v), 1);
        check("rst_fs", int'(frame_start), 0);
        step();
        check("first_x",  int'(x), 0);
        check("first_y",  int'(y), 0);
        check("first_fs", int'(frame_start), 1);
        check("first_von", int'(video_on), 1);
`else
        check("rst_x",  int'(x), 0);
        check("rst_y",  int'(y), 0);
        check("rst_von", int'(video_on), 1);
        check("rst_hs", int'(sync_h), 1);
        check("rst_vs", int'(sync_v), 1);
        check("rst_fs", int'(frame_start), 1);
`endif

        // Small instance: vertical sync window and vertical blanking
        lows = 0; first_low = -1; von_bad = 0; von_on = 0;
        for (int t = 1; t <= 207; t++) begin
            goto(t);
            if (sync_v_s == 1'b0) begin
                lows++;
                if (first_low < 0) first_low = t;
            end
            if (t >= 96 && video_on_s) von_bad++;
            if (t == 87) von_on = int'(video_on_s);
        end
        check("s_vs_lows", lows, 32);
        check("s_vs_first", first_low, 128);
        check("s_von_vblank", von_bad, 0);
        check("s_von_visible", von_on, 1);

        // Small instance: frame wrap at 207 -> 208
        check("s_wrap_x_pre", int'(x_s), 15);
        check("s_wrap_y_pre", int'(y_s), 12);
        check("s_wrap_fs_pre", int'(frame_start_s), 0);
        goto(208);
        check("s_wrap_x", int'(x_s), 0);
        check("s_wrap_y", int'(y_s), 0);
        check("s_wrap_fs", int'(frame_start_s), 1);

        // Small instance: frame period, bounded wait
        n = 0;
        do begin
            step();
            n++;
        end while (frame_start_s !== 1'b1 && n < 1000);
        check("s_frame_period", n, 208);

        // Full-size horizontal timing on line 0
        goto(639);
        check("von_639", int'(video_on), 1);
        goto(640);
        check("von_640", int'(video_on), 0);
        goto(655);
        check("hs_655", int'(sync_h), 1);
        lows = 0; highs = 0;
        for (int t = 656; t <= 751; t++) begin
            goto(t);
            if (sync_h == 1'b0) lows++;
            if (video_on) highs++;
        end
        check("hs_lows", lows, 96);
        check("von_in_hsync", highs, 0);
        goto(752);
        check("hs_752", int'(sync_h), 1);
        goto(799);
        check("von_799", int'(video_on), 0);
        check("x_799", int'(x), 799);

        // Line wrap at y=5
        goto(4798);
        check("lw_x798", int'(x), 798);
        check("lw_y798", int'(y), 5);
        goto(4799);
        check("lw_y799", int'(y), 5);
        goto(4800);
        check("lw_x0", int'(x), 0);
        check("lw_y6", int'(y), 6);
        check("lw_fs", int'(frame_start), 0);

        // Mid-frame reset while sync_h is low (x=700, y=20)
        goto(16700);
        check("mr_pre_x", int'(x), 700);
        check("mr_pre_y", int'(y), 20);
        check("mr_pre_hs", int'(sync_h), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        check("mr_x", int'(x), 0);
        check("mr_y", int'(y), 0);
        check("mr_hs", int'(sync_h), 1);
        check("mr_vs", int'(sync_v), 1);
        goto(805);
        check("mr_resume_x", int'(x), 5);
        check("mr_resume_y", int'(y), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
